grant_decoder: RTL and testbench

GRANT_DECODER -- requirements
Module: grant_decoder

---
 rtl/grant_decoder.sv | 147 ++++++++++++++
 tb/tb_grant_decoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/grant_decoder.sv
// Grant decoder: turns an encoded grant index into a registered one-hot grant, held until the owner's done strobe.
// Latency 1 from index acceptance to gnt; idx_ready is low while a grant or its release cycle is in progress.
// Optional forced release after TIMEOUT grant cycles is compiled in with GRANT_DECODER_TIMEOUT_EN.
module grant_decoder #(
    parameter int N_CLIENTS = 8,
    parameter int IDX_W     = 3,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 idx_valid,
    input  logic [IDX_W-1:0]     idx,
    output logic                 idx_ready,
    input  logic [N_CLIENTS-1:0] done,
    output logic [N_CLIENTS-1:0] gnt,
    output logic                 busy,
    output logic                 bad_idx,
    output logic                 timeout,
    output logic [15:0]          grant_count
);

    if (IDX_W != $clog2(N_CLIENTS) || N_CLIENTS < 2 || N_CLIENTS > 256 ||
        TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("grant_decoder: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [N_CLIENTS-1:0] gnt_q, gnt_d;
    logic                 idx_ready_q, idx_ready_d;
    logic                 busy_q, busy_d;
    logic                 bad_idx_q, bad_idx_d;
    logic [15:0]          grant_count_q, grant_count_d;

    logic                 idx_in_range;
    logic [N_CLIENTS-1:0] onehot_idx;
    logic                 owner_done;
    logic                 expire;

    assign idx_in_range = (32'(idx) < N_CLIENTS);
    assign onehot_idx   = {{(N_CLIENTS-1){1'b0}}, 1'b1} << idx;
    // gnt_q is one-hot on the owner, so masking done with it picks done[owner] only.
    assign owner_done   = |(done & gnt_q);

`ifdef GRANT_DECODER_TIMEOUT_EN
    logic [15:0] hold_q, hold_d;
    logic        timeout_q, timeout_d;

    assign expire = (hold_q == 16'(TIMEOUT - 1));

    always_comb begin
        hold_d    = '0;
        timeout_d = 1'b0;
        if (state_q == GRANT) begin
            hold_d    = hold_q + 16'd1;
            timeout_d = expire && !owner_done;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        idx_ready_d   = 1'b0;
        busy_d        = 1'b0;
        bad_idx_d     = 1'b0;
        grant_count_d = grant_count_q;
        case (state_q)
            IDLE: begin
                idx_ready_d = 1'b1;
                if (idx_valid) begin
                    if (idx_in_range) begin
                        state_d     = GRANT;
                        gnt_d       = onehot_idx;
                        idx_ready_d = 1'b0;
                        busy_d      = 1'b1;
                    end else begin
                        bad_idx_d = 1'b1;
                    end
                end
            end
            GRANT: begin
                busy_d = 1'b1;
                if (owner_done || expire) begin
                    state_d       = RELEASE;
                    gnt_d         = '0;
                    busy_d        = 1'b0;
                    grant_count_d = grant_count_q + 16'd1;
                end
            end
            RELEASE: begin
                state_d     = IDLE;
                idx_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                idx_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            idx_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            bad_idx_q     <= 1'b0;
            grant_count_q <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            idx_ready_q   <= idx_ready_d;
            busy_q        <= busy_d;
            bad_idx_q     <= bad_idx_d;
            grant_count_q <= grant_count_d;
        end
    end

    assign gnt         = gnt_q;
    assign idx_ready   = idx_ready_q;
    assign busy        = busy_q;
    assign bad_idx     = bad_idx_q;
    assign grant_count = grant_count_q;

endmodule

// File: tb/tb_grant_decoder.sv
// Bench for grant_decoder: two instances (8 clients / TIMEOUT 4, and 6 clients) share random and directed stimulus;
// a transaction-level model predicts each cycle's outputs into queues that a monitor drains and compares.
module tb_grant_decoder;

`ifdef GRANT_DECODER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int NA = 8;
    localparam int TA = 4;
    localparam int NB = 6;
    localparam int TB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       idx_valid = 1'b0;
    logic [2:0] idx = '0;
    logic [7:0] done = '0;

    logic        rdy_a, busy_a, bad_a, to_a;
    logic [7:0]  gnt_a;
    logic [15:0] cnt_a;
    logic        rdy_b, busy_b, bad_b, to_b;
    logic [5:0]  gnt_b;
    logic [15:0] cnt_b;

    grant_decoder #(.N_CLIENTS(NA), .IDX_W(3), .TIMEOUT(TA)) dut_a (
        .clk(clk), .rst_n(rst_n), .idx_valid(idx_valid), .idx(idx), .idx_ready(rdy_a),
        .done(done), .gnt(gnt_a), .busy(busy_a), .bad_idx(bad_a), .timeout(to_a),
        .grant_count(cnt_a)
    );

    grant_decoder #(.N_CLIENTS(NB), .IDX_W(3), .TIMEOUT(TB)) dut_b (
        .clk(clk), .rst_n(rst_n), .idx_valid(idx_valid), .idx(idx), .idx_ready(rdy_b),
        .done(done[5:0]), .gnt(gnt_b), .busy(busy_b), .bad_idx(bad_b), .timeout(to_b),
        .grant_count(cnt_b)
    );

    always #5 clk = ~clk;

    // Model state: who owns the grant (-1 none), whether the mandatory gap cycle is pending,
    // how many grant cycles have elapsed, and the completed-grant tally.
    typedef struct {
        int owner;
        bit gap;
        int held;
        int count;
        bit bad;
        bit to;
    } mdl_t;

    typedef struct {
        logic [7:0]  gnt;
        logic        busy;
        logic        rdy;
        logic        bad;
        logic        to;
        logic [15:0] cnt;
    } exp_t;

    mdl_t ma, mb;
    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   preload_req = 1'b0;

    function automatic mdl_t step(mdl_t m, int n, int tmo, bit r, bit v, int i, logic [7:0] d);
        mdl_t s = m;
        s.bad = 1'b0;
        s.to  = 1'b0;
        if (!r) begin
            s.owner = -1; s.gap = 1'b0; s.held = 0; s.count = 0;
        end else if (s.gap) begin
            s.gap = 1'b0;
        end else if (s.owner >= 0) begin
            if (d[s.owner] || (TO_EN && s.held + 1 >= tmo)) begin
                s.to    = !d[s.owner];
                s.owner = -1;
                s.gap   = 1'b1;
                s.count = (s.count + 1) % 65536;
            end else begin
                s.held++;
            end
        end else if (v) begin
            if (i < n) begin
                s.owner = i; s.held = 0;
            end else begin
                s.bad = 1'b1;
            end
        end
        return s;
    endfunction

    function automatic exp_t expect_of(mdl_t m);
        exp_t e;
        e.gnt = '0;
        if (m.owner >= 0) e.gnt[m.owner] = 1'b1;
        e.busy = (m.owner >= 0);
        e.rdy  = (m.owner < 0) && !m.gap;
        e.bad  = m.bad;
        e.to   = m.to;
        e.cnt  = 16'(m.count);
        return e;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(bit r, bit v, logic [2:0] i, logic [7:0] d);
        @(negedge clk);
        if (preload_req) begin
            force dut_a.grant_count_q = 16'hFFFE;
            #1;
            release dut_a.grant_count_q;
            ma.count    = 65534;
            preload_req = 1'b0;
        end
        rst_n = r; idx_valid = v; idx = i; done = d;
        ma = step(ma, NA, TA, r, v, int'(i), d);
        mb = step(mb, NB, TB, r, v, int'(i), d);
        qa.push_back(expect_of(ma));
        qb.push_back(expect_of(mb));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_gnt", 32'(gnt_a), 32'(e.gnt));
                chk("a_busy", 32'(busy_a), 32'(e.busy));
                chk("a_idx_ready", 32'(rdy_a), 32'(e.rdy));
                chk("a_bad_idx", 32'(bad_a), 32'(e.bad));
                chk("a_timeout", 32'(to_a), 32'(e.to));
                chk("a_grant_count", 32'(cnt_a), 32'(e.cnt));
                chk("a_gnt_onehot0", 32'($onehot0(gnt_a)), 32'd1);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_gnt", 32'(gnt_b), 32'(e.gnt));
                chk("b_busy", 32'(busy_b), 32'(e.busy));
                chk("b_idx_ready", 32'(rdy_b), 32'(e.rdy));
                chk("b_bad_idx", 32'(bad_b), 32'(e.bad));
                chk("b_timeout", 32'(to_b), 32'(e.to));
                chk("b_grant_count", 32'(cnt_b), 32'(e.cnt));
                chk("b_gnt_onehot0", 32'($onehot0(gnt_b)), 32'd1);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        ma = '{owner: -1, gap: 1'b0, held: 0, count: 0, bad: 1'b0, to: 1'b0};
        mb = ma;

        cyc(0, 0, 3'd0, 8'h00);
        cyc(0, 0, 3'd0, 8'h00);
        cyc(1, 0, 3'd0, 8'h00);

        // basic grant of client 4, released by its own done
        cyc(1, 1, 3'd4, 8'h00);
        cyc(1, 0, 3'd0, 8'h00);
        cyc(1, 0, 3'd0, 8'h10);
        cyc(1, 0, 3'd0, 8'h00);
        cyc(1, 0, 3'd0, 8'h00);

        // foreign done and a competing index while client 3 holds the grant
        cyc(1, 1, 3'd3, 8'h00);
        cyc(1, 0, 3'd0, 8'h80);
        cyc(1, 1, 3'd5, 8'h00);
        cyc(1, 1, 3'd5, 8'h08);
        cyc(1, 0, 3'd0, 8'h00);
        cyc(1, 0, 3'd0, 8'h00);

        // index 7: out of range for the 6-client instance
        cyc(1, 1, 3'd7, 8'h00);
        cyc(1, 0, 3'd0, 8'h80);
        cyc(1, 0, 3'd0, 8'h00);
        cyc(1, 0, 3'd0, 8'h00);

        // reset while client 0 holds the grant
        cyc(1, 1, 3'd0, 8'h00);
        cyc(1, 0, 3'd0, 8'h00);
        cyc(0, 0, 3'd0, 8'h00);
        cyc(1, 0, 3'd0, 8'h00);
        cyc(1, 0, 3'd0, 8'h00);

        // grant to client 2 with no done for a long stretch
        cyc(1, 1, 3'd2, 8'h00);
        for (int k = 0; k < 8; k++) cyc(1, 0, 3'd0, 8'h00);
        cyc(1, 0, 3'd0, 8'h04);
        cyc(1, 0, 3'd0, 8'h00);
        cyc(1, 0, 3'd0, 8'h00);

        // counter wrap with back-to-back grants, valid and done held high
        preload_req = 1'b1;
        for (int k = 0; k < 10; k++) cyc(1, 1, 3'd1, 8'hFF);
        cyc(1, 0, 3'd0, 8'h00);
        cyc(1, 0, 3'd0, 8'h00);

        for (int k = 0; k < 1500; k++) begin
            cyc(($urandom_range(0, 99) != 0), 1'($urandom), 3'($urandom),
                8'($urandom & $urandom & $urandom));
        end
        for (int k = 0; k < 3; k++) cyc(1, 0, 3'd0, 8'h00);

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(qa.size() + qb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
